sfx_scheduler: RTL and testbench

Shares the single tone path (note code → divider → square-wave generator) between the background-music sequencer and three game sound effects: piece drop, line clear and game over. When idle, it passes the background-music note code through. On a sound-effect request it holds the music sequencer, plays the effect's note sequence from a small ROM, inserts a one-step rest, and then hands the tone path back. It sits between the music sequencer/note memory and the divisor calculator, and its `note` output drives the divisor input directly.

---
 rtl/sfx_scheduler_pkg.sv | 35 +++
 rtl/sfx_scheduler_if.sv | 18 +
 rtl/sfx_scheduler_rom.sv | 54 +++++
 rtl/sfx_scheduler.sv | 111 +++++++++++
 tb/tb_sfx_scheduler.sv | 129 ++++++++++++
 5 files changed

// File: rtl/sfx_scheduler_pkg.sv
// Shared types and constants for the sound-effect scheduler: FSM states, effect ids,
// note codes and effect lengths.
package sfx_pkg;

  localparam int NOTE_W = 5;
  localparam int STEP_W = 3;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_TAIL, ST_SILENT} state_e;
  typedef enum logic [1:0] {SFX_NONE = 2'd0, SFX_DROP = 2'd1, SFX_CLEAR = 2'd2, SFX_OVER = 2'd3} sfx_id_e;

  // Low (L), mid (M) and high (H) octave scale degrees 1-7.
  localparam note_t NOTE_REST = 5'd0;
  localparam note_t NOTE_L1 = 5'd1,  NOTE_L2 = 5'd2,  NOTE_L3 = 5'd3,  NOTE_L4 = 5'd4;
  localparam note_t NOTE_L5 = 5'd5,  NOTE_L6 = 5'd6,  NOTE_L7 = 5'd7;
  localparam note_t NOTE_M1 = 5'd8,  NOTE_M2 = 5'd9,  NOTE_M3 = 5'd10, NOTE_M4 = 5'd11;
  localparam note_t NOTE_M5 = 5'd12, NOTE_M6 = 5'd13, NOTE_M7 = 5'd14;
  localparam note_t NOTE_H1 = 5'd15, NOTE_H2 = 5'd16, NOTE_H3 = 5'd17, NOTE_H4 = 5'd18;
  localparam note_t NOTE_H5 = 5'd19, NOTE_H6 = 5'd20, NOTE_H7 = 5'd21;

  localparam step_t LEN_DROP  = 3'd2;
  localparam step_t LEN_CLEAR = 3'd4;
  localparam step_t LEN_OVER  = 3'd6;

  // Highest set request bit wins: game over > line clear > drop.
  function automatic sfx_id_e sfx_pick(input logic [2:0] req);
    if (req[2])      return SFX_OVER;
    else if (req[1]) return SFX_CLEAR;
    else if (req[0]) return SFX_DROP;
    else             return SFX_NONE;
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Tone-path sharing bus between the game/music side (master) and the scheduler (slave).
interface sfx_scheduler_if;
  import sfx_pkg::*;

  note_t      bgm_note;
  logic [2:0] sfx_req;
  logic       restart;
  logic       mute;
  note_t      note;
  logic       bgm_hold;
  logic       sfx_busy;
  logic [1:0] sfx_id;

  modport master (output bgm_note, sfx_req, restart, mute,
                  input  note, bgm_hold, sfx_busy, sfx_id);
  modport slave  (input  bgm_note, sfx_req, restart, mute,
                  output note, bgm_hold, sfx_busy, sfx_id);
endinterface

// File: rtl/sfx_scheduler_rom.sv
// Effect note ROM: (id, step) -> note code plus a flag marking the effect's final step.
module sfx_rom
  import sfx_pkg::*;
(
  input  sfx_id_e id,
  input  step_t   step,
  output note_t   note,
  output logic    last
);
  localparam step_t LAST_DROP  = LEN_DROP  - 3'd1;
  localparam step_t LAST_CLEAR = LEN_CLEAR - 3'd1;
  localparam step_t LAST_OVER  = LEN_OVER  - 3'd1;

  always_comb begin
    note = NOTE_REST;
    last = 1'b0;
    case (id)
      SFX_DROP: begin
        last = (step == LAST_DROP);
        case (step)
          3'd0: note = NOTE_M5;
          3'd1: note = NOTE_L5;
          default: note = NOTE_REST;
        endcase
      end
      SFX_CLEAR: begin
        last = (step == LAST_CLEAR);
        case (step)
          3'd0: note = NOTE_H1;
          3'd1: note = NOTE_H3;
          3'd2: note = NOTE_H5;
          3'd3: note = NOTE_H7;
          default: note = NOTE_REST;
        endcase
      end
      SFX_OVER: begin
        last = (step == LAST_OVER);
        case (step)
          3'd0: note = NOTE_M6;
          3'd1: note = NOTE_M5;
          3'd2: note = NOTE_M4;
          3'd3: note = NOTE_M3;
          3'd4: note = NOTE_M2;
          3'd5: note = NOTE_M1;
          default: note = NOTE_REST;
        endcase
      end
      default: begin
        note = NOTE_REST;
        last = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/sfx_scheduler.sv
// Shares the tone path between background music and sound effects; all outputs are
// registered from next-state values so a request shows its first note one cycle later.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int T_STEP = 2_500_000
)(
  input  logic             clk,
  input  logic             rst,
  sfx_scheduler_if.slave   bus
);
  localparam int TW = (T_STEP > 1) ? $clog2(T_STEP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(T_STEP - 1);

  state_e        state_q, state_n;
  sfx_id_e       id_q, id_n, req_id, out_id_q;
  step_t         step_q, step_n;
  logic [TW-1:0] tmr_q, tmr_n;
  note_t         note_q, play_note, unused_note;
  logic          hold_q, busy_q, cur_last, unused_last, step_end;

  assign req_id   = sfx_pick(bus.sfx_req);
  assign step_end = (tmr_q == T_LAST);

  // One ROM answers "is this the final step" for the current position, the other
  // supplies the note for the position being entered.
  sfx_rom u_rom_cur (.id(id_q), .step(step_q), .note(unused_note), .last(cur_last));
  sfx_rom u_rom_nxt (.id(id_n), .step(step_n), .note(play_note),   .last(unused_last));

  always_comb begin
    state_n = state_q;
    id_n    = id_q;
    step_n  = step_q;
    tmr_n   = tmr_q;
    case (state_q)
      ST_IDLE, ST_TAIL: begin
        if (req_id != SFX_NONE) begin
          state_n = ST_PLAY;
          id_n    = req_id;
          step_n  = '0;
          tmr_n   = '0;
        end else if (state_q == ST_TAIL) begin
          if (step_end) begin
            state_n = ST_IDLE;
            id_n    = SFX_NONE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // Preemption beats a coincident last-step end; equal/lower requests are dropped.
        if (req_id > id_q) begin
          id_n   = req_id;
          step_n = '0;
          tmr_n  = '0;
        end else if (step_end) begin
          tmr_n = '0;
          if (cur_last) begin
            state_n = (id_q == SFX_OVER) ? ST_SILENT : ST_TAIL;
            step_n  = '0;
          end else begin
            step_n = step_q + 3'd1;
          end
        end else begin
          tmr_n = tmr_q + 1'b1;
        end
      end
      ST_SILENT: begin
        if (bus.restart) begin
          state_n = ST_IDLE;
          id_n    = SFX_NONE;
          tmr_n   = '0;
          step_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      id_q     <= SFX_NONE;
      step_q   <= '0;
      tmr_q    <= '0;
      note_q   <= NOTE_REST;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
      out_id_q <= SFX_NONE;
    end else begin
      state_q <= state_n;
      id_q    <= id_n;
      step_q  <= step_n;
      tmr_q   <= tmr_n;
      if (bus.mute)                note_q <= NOTE_REST;
      else if (state_n == ST_IDLE) note_q <= bus.bgm_note;
      else if (state_n == ST_PLAY) note_q <= play_note;
      else                         note_q <= NOTE_REST;
      hold_q   <= (state_n != ST_IDLE);
      busy_q   <= (state_n == ST_PLAY) || (state_n == ST_TAIL);
      out_id_q <= ((state_n == ST_PLAY) || (state_n == ST_TAIL)) ? id_n : SFX_NONE;
    end
  end

  assign bus.note     = note_q;
  assign bus.bgm_hold = hold_q;
  assign bus.sfx_busy = busy_q;
  assign bus.sfx_id   = out_id_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
// Cycle-by-cycle vector bench for sfx_scheduler with T_STEP=4.
module tb_sfx_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfx_scheduler_if bif();
  sfx_scheduler #(.T_STEP(4)) dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    string      tag;
    logic       r;
    logic [4:0] bgm;
    logic [2:0] req;
    logic       rs;
    logic       m;
    logic [4:0] note;
    logic       hold;
    logic       busy;
    logic [1:0] id;
    logic       id_dc;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];
  int errors = 0;
  int checks = 0;

  // Push n identical cycles: inputs, then outputs expected right after that edge.
  task automatic add(input int n, input string tag, input int r, input int bgm, input int req,
                     input int rs, input int m, input int note, input int hold, input int busy,
                     input int id, input int dc = 0);
    vec_t v;
    v.tag = tag; v.r = 1'(r); v.bgm = 5'(bgm); v.req = 3'(req); v.rs = 1'(rs); v.m = 1'(m);
    v.note = 5'(note); v.hold = 1'(hold); v.busy = 1'(busy); v.id = 2'(id); v.id_dc = 1'(dc);
    for (int i = 0; i < n; i++) tv.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.r; bif.bgm_note = v.bgm; bif.sfx_req = v.req; bif.restart = v.rs; bif.mute = v.m;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bif.note !== e.note || bif.bgm_hold !== e.hold || bif.sfx_busy !== e.busy ||
        (!e.id_dc && bif.sfx_id !== e.id)) begin
      errors++;
      $display("FAIL %s note/hold/busy/id got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d",
               e.tag, bif.note, bif.bgm_hold, bif.sfx_busy, bif.sfx_id,
               e.note, e.hold, e.busy, e.id);
    end
  endtask

  initial begin
    rst = 1'b1; bif.bgm_note = '0; bif.sfx_req = '0; bif.restart = 1'b0; bif.mute = 1'b0;

    // Reset and idle pass-through
    add(2, "reset",      1, 17, 0, 0, 0, 0,  0, 0, 0);
    add(1, "idle_pass",  0, 17, 0, 0, 0, 17, 0, 0, 0);
    add(1, "idle_pass2", 0, 3,  0, 0, 0, 3,  0, 0, 0);
    // Drop pulse: 12 x4, 5 x4, rest x4, then music
    add(1, "drop",      0, 9, 1, 0, 0, 12, 1, 1, 1);
    add(3, "drop_s0",   0, 9, 0, 0, 0, 12, 1, 1, 1);
    add(4, "drop_s1",   0, 9, 0, 0, 0, 5,  1, 1, 1);
    add(4, "drop_tail", 0, 9, 0, 0, 0, 0,  1, 1, 1);
    add(1, "drop_done", 0, 9, 0, 0, 0, 9,  0, 0, 0);
    // Drop+clear together: clear wins
    add(1, "pri",      0, 6, 3, 0, 0, 15, 1, 1, 2);
    add(3, "pri_s0",   0, 6, 0, 0, 0, 15, 1, 1, 2);
    add(4, "pri_s1",   0, 6, 0, 0, 0, 17, 1, 1, 2);
    add(4, "pri_s2",   0, 6, 0, 0, 0, 19, 1, 1, 2);
    add(4, "pri_s3",   0, 6, 0, 0, 0, 21, 1, 1, 2);
    add(4, "pri_tail", 0, 6, 0, 0, 0, 0,  1, 1, 2);
    add(1, "pri_done", 0, 6, 0, 0, 0, 6,  0, 0, 0);
    // Clear preempted by game over at step 1, then silence and restart
    add(1, "clr",        0, 6, 2, 0, 0, 15, 1, 1, 2);
    add(3, "clr_s0",     0, 6, 0, 0, 0, 15, 1, 1, 2);
    add(1, "clr_s1",     0, 6, 0, 0, 0, 17, 1, 1, 2);
    add(1, "preempt",    0, 6, 4, 0, 0, 13, 1, 1, 3);
    add(3, "over_s0",    0, 6, 0, 0, 0, 13, 1, 1, 3);
    add(4, "over_s1",    0, 6, 0, 0, 0, 12, 1, 1, 3);
    add(4, "over_s2",    0, 6, 0, 0, 0, 11, 1, 1, 3);
    add(4, "over_s3",    0, 6, 0, 0, 0, 10, 1, 1, 3);
    add(4, "over_s4",    0, 6, 0, 0, 0, 9,  1, 1, 3);
    add(4, "over_s5",    0, 6, 0, 0, 0, 8,  1, 1, 3);
    add(1, "silent",     0, 6, 0, 0, 0, 0,  1, 0, 0, 1);
    add(2, "silent_req", 0, 6, 1, 0, 0, 0,  1, 0, 0, 1);
    add(1, "restart",    0, 6, 1, 1, 0, 6,  0, 0, 0);
    add(2, "no_drop",    0, 6, 0, 0, 0, 6,  0, 0, 0);
    // Drop re-requested throughout PLAY is ignored; a request in TAIL restarts it
    add(1, "redrop",     0, 4, 1, 0, 0, 12, 1, 1, 1);
    add(3, "redrop_s0",  0, 4, 1, 0, 0, 12, 1, 1, 1);
    add(4, "redrop_s1",  0, 4, 1, 0, 0, 5,  1, 1, 1);
    add(2, "redrop_tl",  0, 4, 0, 0, 0, 0,  1, 1, 1);
    add(1, "tail_req",   0, 4, 1, 0, 0, 12, 1, 1, 1);
    add(3, "tail_s0",    0, 4, 0, 0, 0, 12, 1, 1, 1);
    add(4, "tail_s1",    0, 4, 0, 0, 0, 5,  1, 1, 1);
    add(4, "tail_tail",  0, 4, 0, 0, 0, 0,  1, 1, 1);
    add(1, "tail_done",  0, 4, 0, 0, 0, 4,  0, 0, 0);
    // Mute during line clear: silent output, unchanged hold timing
    add(1,  "mute",      0, 6, 2, 0, 1, 0, 1, 1, 2);
    add(19, "mute_run",  0, 6, 0, 0, 1, 0, 1, 1, 2);
    add(1,  "mute_idle", 0, 6, 0, 0, 1, 0, 0, 0, 0);
    add(1,  "unmute",    0, 6, 0, 0, 0, 6, 0, 0, 0);
    // Reset mid-PLAY, no resume afterwards
    add(2, "rst_play", 0, 7, 1, 0, 0, 12, 1, 1, 1);
    add(1, "rst_mid",  1, 7, 0, 0, 0, 0,  0, 0, 0);
    add(2, "post_rst", 0, 7, 0, 0, 0, 7,  0, 0, 0);
    // Clear request on the drop's final cycle beats the move to TAIL
    add(1, "late",      0, 2, 1, 0, 0, 12, 1, 1, 1);
    add(3, "late_s0",   0, 2, 0, 0, 0, 12, 1, 1, 1);
    add(4, "late_s1",   0, 2, 0, 0, 0, 5,  1, 1, 1);
    add(1, "late_pre",  0, 2, 2, 0, 0, 15, 1, 1, 2);
    add(3, "late_c0",   0, 2, 0, 0, 0, 15, 1, 1, 2);
    add(4, "late_c1",   0, 2, 0, 0, 0, 17, 1, 1, 2);
    add(4, "late_c2",   0, 2, 0, 0, 0, 19, 1, 1, 2);
    add(4, "late_c3",   0, 2, 0, 0, 0, 21, 1, 1, 2);
    add(4, "late_tail", 0, 2, 0, 0, 0, 0,  1, 1, 2);
    add(1, "late_done", 0, 2, 0, 0, 0, 2,  0, 0, 0);

    for (int i = 0; i < tv.size(); i++) apply(tv[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
